// File: rtl/dac_serial_tx.sv
// dac_serial_tx: multi-channel I2S / left-justified / TDM DAC serialiser
// with SCLK/BCLK dividers and a one-frame holding register.
module dac_serial_tx #(
  parameter int BIT_WIDTH  = 10,
  parameter int SLOT_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int MODE       = 0,
  parameter int BCLK_DIV   = 38,
  parameter int SCLK_DIV   = 0
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic [CHANNELS*BIT_WIDTH-1:0] IN_DATA,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic                          DAC_SCLK,
  output logic                          DAC_BCLK,
  output logic                          DAC_LRCLK,
  output logic                          DAC_SDATA,
  output logic                          FRAME_START,
  output logic                          UNDERRUN
);

  localparam int DW = CHANNELS * BIT_WIDTH;
  localparam int SW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int CW = $clog2(CHANNELS);
  localparam int BW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [SW-1:0] BIT_LAST  = SW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CHANNELS - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BCLK_DIV - 1);

  logic [BW-1:0] bcnt;
  logic [SW-1:0] bis;
  logic [SW-1:0] bis_nxt;
  logic [CW-1:0] slot;
  logic [CW-1:0] slot_nxt;

  logic          hold_full;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] latch;
  logic [DW-1:0] latch_nxt;

  logic bclk_fall;
  logic last_bit;
  logic wrap;
  logic load;
  logic xfer;
  logic sd_nxt;
  logic lr_nxt;

  logic [SLOT_WIDTH-1:0] cur_slots [CHANNELS];
  logic [SLOT_WIDTH-1:0] nxt_slots [CHANNELS];

  assign bclk_fall = DAC_BCLK && (bcnt == BCNT_LAST);
  assign last_bit  = (bis == BIT_LAST);
  assign wrap      = last_bit && (slot == SLOT_LAST);
  assign load      = bclk_fall && wrap;
  assign xfer      = IN_VALID && !hold_full;
  assign IN_READY  = !hold_full;
  assign latch_nxt = (load && hold_full) ? hold_data : latch;

  always_comb begin
    bis_nxt  = last_bit ? '0 : bis + 1'b1;
    slot_nxt = slot;
    if (last_bit) begin
      slot_nxt = wrap ? '0 : slot + 1'b1;
    end
  end

  // Slot vectors indexed by bit position in the slot: MSB first, zero tail.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    for (genvar b = 0; b < SLOT_WIDTH; b++) begin : g_bit
      if (b < BIT_WIDTH) begin : g_d
        assign cur_slots[k][b] = latch[k*BIT_WIDTH + BIT_WIDTH - 1 - b];
        assign nxt_slots[k][b] = latch_nxt[k*BIT_WIDTH + BIT_WIDTH - 1 - b];
      end else begin : g_z
        assign cur_slots[k][b] = 1'b0;
        assign nxt_slots[k][b] = 1'b0;
      end
    end
  end

  // I2S lags by one bit: the old position of the old frame is the new bit.
  if (MODE == 1) begin : g_lj
    assign sd_nxt = nxt_slots[slot_nxt][bis_nxt];
  end else begin : g_i2s
    assign sd_nxt = cur_slots[slot][bis];
  end

  if (CHANNELS == 2) begin : g_ws
    assign lr_nxt = slot_nxt[0];
  end else begin : g_fsync
    assign lr_nxt = (slot_nxt == '0) && (bis_nxt == '0);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      bcnt     <= '0;
      DAC_BCLK <= 1'b0;
    end else if (bcnt == BCNT_LAST) begin
      bcnt     <= '0;
      DAC_BCLK <= !DAC_BCLK;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      bis       <= BIT_LAST;
      slot      <= SLOT_LAST;
      DAC_SDATA <= 1'b0;
      DAC_LRCLK <= 1'b0;
    end else if (bclk_fall) begin
      bis       <= bis_nxt;
      slot      <= slot_nxt;
      DAC_SDATA <= sd_nxt;
      DAC_LRCLK <= lr_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      hold_full   <= 1'b0;
      hold_data   <= '0;
      latch       <= '0;
      FRAME_START <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      FRAME_START <= load;
      UNDERRUN    <= load && !hold_full;
      latch       <= latch_nxt;
      if (xfer) begin
        hold_data <= IN_DATA;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  if (SCLK_DIV > 0) begin : g_sclk
    localparam int SCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(SCLK_DIV - 1);
    logic [SCW-1:0] scnt;
    always_ff @(posedge CLK) begin
      if (!RESET_n) begin
        scnt     <= '0;
        DAC_SCLK <= 1'b0;
      end else if (scnt == SCNT_LAST) begin
        scnt     <= '0;
        DAC_SCLK <= !DAC_SCLK;
      end else begin
        scnt <= scnt + 1'b1;
      end
    end
  end else begin : g_no_sclk
    assign DAC_SCLK = 1'b0;
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: three configurations (2ch LJ, 2ch I2S, 4ch TDM LJ)
// checked every cycle against a cycle-count based frame model.
module tb_dac_serial_tx;

  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [19:0] d0;
  logic [19:0] d1;
  logic [39:0] d2;
  logic [2:0]  vin;
  logic [2:0]  rdy;
  logic [2:0]  sclk;
  logic [2:0]  bclk;
  logic [2:0]  lrclk;
  logic [2:0]  sdata;
  logic [2:0]  fs;
  logic [2:0]  ur;

  dac_serial_tx #(
    .BIT_WIDTH(10), .SLOT_WIDTH(16), .CHANNELS(2),
    .MODE(1), .BCLK_DIV(BD), .SCLK_DIV(2)
  ) u0 (
    .CLK(clk), .RESET_n(rst_n), .IN_DATA(d0), .IN_VALID(vin[0]),
    .IN_READY(rdy[0]), .DAC_SCLK(sclk[0]), .DAC_BCLK(bclk[0]),
    .DAC_LRCLK(lrclk[0]), .DAC_SDATA(sdata[0]),
    .FRAME_START(fs[0]), .UNDERRUN(ur[0])
  );

  dac_serial_tx #(
    .BIT_WIDTH(10), .SLOT_WIDTH(16), .CHANNELS(2),
    .MODE(0), .BCLK_DIV(BD), .SCLK_DIV(0)
  ) u1 (
    .CLK(clk), .RESET_n(rst_n), .IN_DATA(d1), .IN_VALID(vin[1]),
    .IN_READY(rdy[1]), .DAC_SCLK(sclk[1]), .DAC_BCLK(bclk[1]),
    .DAC_LRCLK(lrclk[1]), .DAC_SDATA(sdata[1]),
    .FRAME_START(fs[1]), .UNDERRUN(ur[1])
  );

  dac_serial_tx #(
    .BIT_WIDTH(10), .SLOT_WIDTH(16), .CHANNELS(4),
    .MODE(1), .BCLK_DIV(BD), .SCLK_DIV(3)
  ) u2 (
    .CLK(clk), .RESET_n(rst_n), .IN_DATA(d2), .IN_VALID(vin[2]),
    .IN_READY(rdy[2]), .DAC_SCLK(sclk[2]), .DAC_BCLK(bclk[2]),
    .DAC_LRCLK(lrclk[2]), .DAC_SDATA(sdata[2]),
    .FRAME_START(fs[2]), .UNDERRUN(ur[2])
  );

  int checks = 0;
  int errors = 0;

  int chs [3] = '{2, 2, 4};
  int mds [3] = '{1, 0, 1};
  int sds [3] = '{2, 0, 3};
  int lim [3] = '{1000, 1000, 2000};

  logic [39:0] tab [3][3];
  int          idx [3];
  bit          drv_en = 1'b0;
  int          phase = 0;

  int          c = 0;
  bit          started = 1'b0;
  bit          full [3];
  logic [39:0] hold [3];
  logic [39:0] cur [3];
  logic [39:0] prev [3];
  logic        efs [3];
  logic        eur [3];
  bit          acc [3];

  int          first_rise = -1;
  int          first_fall = -1;
  int          first_srise = -1;
  int          first_fs = -1;
  logic        first_ur = 1'b0;
  logic [63:0] cap [3];
  logic [63:0] lrc [3];
  int          urc [3];
  logic        rdy1, rdy8, rdy9;

  task automatic check(input string nm, input int k, input logic act,
                       input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle=%0d got=%b want=%b", nm, k, c, act, exp);
    end
  endtask

  task automatic check_v(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] din(input int k);
    if (k == 0) return {20'b0, d0};
    if (k == 1) return {20'b0, d1};
    return d2;
  endfunction

  task automatic set_data(input int k);
    if (k == 0) d0 = tab[0][idx[0]][19:0];
    else if (k == 1) d1 = tab[1][idx[1]][19:0];
    else d2 = tab[2][idx[2]];
  endtask

  // Bit j of a frame's serial stream: channel j/16, MSB first, zero tail.
  function automatic logic slot_bit(input logic [39:0] f, input int j);
    int s;
    int b;
    s = j / 16;
    b = j % 16;
    if (b >= 10) return 1'b0;
    return f[s*10 + 9 - b];
  endfunction

  function automatic logic exp_sd(input int k);
    int n;
    int fb;
    int i;
    n = c / (2*BD);
    if (n == 0) return 1'b0;
    fb = chs[k] * 16;
    i = (n - 1) % fb;
    if (mds[k] == 1) return slot_bit(cur[k], i);
    if (i == 0) return slot_bit(prev[k], fb - 1);
    return slot_bit(cur[k], i - 1);
  endfunction

  function automatic logic exp_lr(input int k);
    int n;
    int fb;
    int i;
    n = c / (2*BD);
    if (n == 0) return 1'b0;
    fb = chs[k] * 16;
    i = (n - 1) % fb;
    if (chs[k] == 2) return (i >= 16);
    return (i == 0);
  endfunction

  // Reference model: frame timing from the cycle count since reset.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      c = 0;
      started = 1'b1;
      for (int k = 0; k < 3; k++) begin
        full[k] = 1'b0;
        cur[k] = '0;
        prev[k] = '0;
        efs[k] = 1'b0;
        eur[k] = 1'b0;
        acc[k] = 1'b0;
      end
    end else begin
      c = c + 1;
      for (int k = 0; k < 3; k++) begin
        int n;
        int fb;
        bit ld;
        bit x;
        fb = chs[k] * 16;
        n = c / (2*BD);
        ld = (c % (2*BD) == 0) && (n >= 1) && ((n - 1) % fb == 0);
        x = vin[k] && !full[k];
        efs[k] = ld;
        eur[k] = ld && !full[k];
        if (ld) begin
          prev[k] = cur[k];
          if (full[k]) cur[k] = hold[k];
        end
        if (x) begin
          hold[k] = din(k);
          full[k] = 1'b1;
        end else if (ld) begin
          full[k] = 1'b0;
        end
        acc[k] = x;
      end
    end
  end

  // Stimulus feeder: next frame after every accepted transfer.
  initial forever begin
    @(negedge clk);
    if (drv_en) begin
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) begin
          idx[k]++;
          if (idx[k] < 3) set_data(k);
          else vin[k] = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare and literal captures.
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic es;
        es = (sds[k] == 0) ? 1'b0 : (((c / sds[k]) % 2) == 1);
        check("bclk", k, bclk[k], ((c / BD) % 2) == 1);
        check("sclk", k, sclk[k], es);
        check("sdata", k, sdata[k], exp_sd(k));
        check("lrclk", k, lrclk[k], exp_lr(k));
        check("frame_start", k, fs[k], efs[k]);
        check("underrun", k, ur[k], eur[k]);
        check("in_ready", k, rdy[k], !full[k]);
      end
      if (phase == 1) begin
        if (bclk[0] && first_rise < 0) first_rise = c;
        if (!bclk[0] && first_rise >= 0 && first_fall < 0) first_fall = c;
        if (sclk[0] && first_srise < 0) first_srise = c;
        if (fs[0] && first_fs < 0) begin
          first_fs = c;
          first_ur = ur[0];
        end
      end
      if (phase == 2 && rst_n) begin
        if (c == 1) rdy1 = rdy[0];
        if (c == 8) rdy8 = rdy[0];
        if (c == 9) rdy9 = rdy[0];
        for (int k = 0; k < 3; k++) begin
          int n;
          int fb;
          if (ur[k] && c <= lim[k]) urc[k]++;
          n = c / (2*BD);
          fb = chs[k] * 16;
          if (c % (2*BD) == 0 && n >= 1 && (n - 1) / fb == 0) begin
            cap[k][63 - (n - 1)] = sdata[k];
            lrc[k][63 - (n - 1)] = lrclk[k];
          end
        end
      end
    end
  end

  initial begin
    tab[0][0] = {20'b0, 10'h15A, 10'h2A5};
    tab[0][1] = {20'b0, 10'h2E7, 10'h1C3};
    tab[0][2] = {20'b0, 10'h3FE, 10'h001};
    tab[1] = tab[0];
    tab[2][0] = {10'h000, 10'h200, 10'h001, 10'h3FF};
    tab[2][1] = {10'h155, 10'h0AA, 10'h3C0, 10'h00F};
    tab[2][2] = {10'h111, 10'h222, 10'h333, 10'h044};
    for (int k = 0; k < 3; k++) begin
      cap[k] = '0;
      lrc[k] = '0;
      urc[k] = 0;
      idx[k] = 0;
    end
    rdy1 = 1'bx;
    rdy8 = 1'bx;
    rdy9 = 1'bx;

    rst_n = 1'b0;
    vin = 3'b000;
    d0 = '0;
    d1 = '0;
    d2 = '0;
    phase = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_v("first_bclk_rise", 64'(first_rise), 64'd4);
    check_v("first_bclk_fall", 64'(first_fall), 64'd8);
    check_v("first_sclk_rise", 64'(first_srise), 64'd2);
    check_v("first_frame_start", 64'(first_fs), 64'd8);
    check_v("first_underrun", 64'(first_ur), 64'd1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    phase = 2;
    for (int k = 0; k < 3; k++) set_data(k);
    vin = 3'b111;
    drv_en = 1'b1;
    rst_n = 1'b1;
    repeat (2100) @(negedge clk);

    check_v("lj_frame0", {32'b0, cap[0][63:32]},
            {32'b0, 32'b1010100101_000000_0101011010_000000});
    check_v("i2s_frame0", {32'b0, cap[1][63:32]},
            {32'b0, 32'b0_1010100101_000000_0101011010_00000});
    check_v("ws_2ch", {32'b0, lrc[0][63:32]}, 64'h0000_0000_0000_FFFF);
    check_v("ws_2ch_i2s", {32'b0, lrc[1][63:32]}, 64'h0000_0000_0000_FFFF);
    check_v("tdm_slot0", {48'b0, cap[2][63:48]}, {48'b0, 16'b1111111111_000000});
    check_v("tdm_slot1", {48'b0, cap[2][47:32]}, {48'b0, 16'b0000000001_000000});
    check_v("tdm_slot2", {48'b0, cap[2][31:16]}, {48'b0, 16'b1000000000_000000});
    check_v("tdm_fsync", lrc[2], 64'h8000_0000_0000_0000);
    check_v("ready_c1", 64'(rdy1), 64'd0);
    check_v("ready_c8", 64'(rdy8), 64'd1);
    check_v("ready_c9", 64'(rdy9), 64'd0);
    check_v("underruns_2ch", 64'(urc[0]), 64'd1);
    check_v("underruns_4ch", 64'(urc[2]), 64'd1);

    while (c % 8 != 3) @(negedge clk);
    drv_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_bclk", k, bclk[k], 1'b0);
      check("rst_sclk", k, sclk[k], 1'b0);
      check("rst_lrclk", k, lrclk[k], 1'b0);
      check("rst_sdata", k, sdata[k], 1'b0);
      check("rst_fs", k, fs[k], 1'b0);
      check("rst_ur", k, ur[k], 1'b0);
      check("rst_ready", k, rdy[k], 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
